bitwise_logic_unit: RTL



---
 rtl/bitwise_logic_pkg.sv | 21 ++
 rtl/bitwise_logic_slice.sv | 24 ++
 rtl/bitwise_logic_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bitwise_logic_pkg.sv
// Shared encodings for the multi-cycle bitwise logic unit: operation codes,
// FSM state codes and a counter-width helper.
package bitwise_logic_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND = 2'b00;
  localparam op_t OP_OR  = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_NOR = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // A single-beat unit still needs a 1-bit counter to keep the ports legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitwise_logic_slice.sv
// Combinational SLICE-bit operator: AND, OR, XOR or NOR of one operand slice.
module logic_slice
  import bitwise_logic_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  op_t              op_i,
  output logic [SLICE-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-wide operator walks the operands
// over N = WIDTH/SLICE beats and publishes a registered result with zero flag.
//
// state | meaning
// IDLE  | waiting for start; result/result_zero hold the last completed value
// RUN   | one operand slice per cycle written into the work register
// DONE  | single cycle: result_rdy high, new start accepted back-to-back
module bitwise_logic_unit
  import bitwise_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  output logic             busy_o,
  output logic             result_rdy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_zero_o
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  if ((SLICE == 0) || (WIDTH % SLICE != 0) || (N < 1)) begin : g_bad_params
    $error("bitwise_logic_unit: WIDTH must be a non-zero multiple of SLICE");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [31:0]      base;
  logic [SLICE-1:0] a_sl, b_sl, y_sl;

  always_comb begin
    base = 32'(cnt_q) * SLICE;
    a_sl = a_q[base +: SLICE];
    b_sl = b_q[base +: SLICE];
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a_i (a_sl),
    .b_i (b_sl),
    .op_i(op_q),
    .y_o (y_sl)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          op_d    = op_i;
          a_d     = data_a_i;
          b_d     = data_b_i;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[base +: SLICE] = y_sl;
        cnt_d = cnt_q + CW'(1);
        // Publish the work value including the slice written this cycle.
        if (cnt_q == LAST_BEAT) begin
          cnt_d    = '0;
          result_d = work_d;
          zero_d   = (work_d == '0);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o        = (state_q == RUN);
  assign result_rdy_o  = (state_q == DONE);
  assign result_o      = result_q;
  assign result_zero_o = zero_q;

endmodule
